// File: rtl/agh_arb_pkg.sv
// rtl/agh_arb_pkg.sv - FSM state, master index and response codes shared by the CSR arbiter
package agh_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_t;

  typedef logic mst_idx_t;

  localparam mst_idx_t   MST_M0      = 1'b0;
  localparam mst_idx_t   MST_M1      = 1'b1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/agh_rr_arb.sv
// rtl/agh_rr_arb.sv - two-way round-robin grant; on a tie the master not granted last wins
module agh_rr_arb
  import agh_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = (last == MST_M1) ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/agh_csr_arbiter.sv
// rtl/agh_csr_arbiter.sv - shares one Avalon-MM CSR slave between m0 and m1; AGH_ARB_TIMEOUT_EN adds a response timeout
module agh_csr_arbiter
  import agh_arb_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [3:0]        m0_byteenable,
  input  logic [31:0]       m0_writedata,
  output logic              m0_waitrequest,
  output logic              m0_readdatavalid,
  output logic              m0_writeresponsevalid,
  output logic [1:0]        m0_response,
  output logic [31:0]       m0_readdata,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [3:0]        m1_byteenable,
  input  logic [31:0]       m1_writedata,
  output logic              m1_waitrequest,
  output logic              m1_readdatavalid,
  output logic              m1_writeresponsevalid,
  output logic [1:0]        m1_response,
  output logic [31:0]       m1_readdata,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [3:0]        s_byteenable,
  output logic [31:0]       s_writedata,
  input  logic              s_waitrequest,
  input  logic              s_readdatavalid,
  input  logic              s_writeresponsevalid,
  input  logic [1:0]        s_response,
  input  logic [31:0]       s_readdata,
  output logic              err_timeout
);

  arb_state_t  state;
  mst_idx_t    gnt;
  mst_idx_t    last;
  logic [1:0]  req;
  logic [1:0]  rr_grant;
  logic        g_read;
  logic        g_write;
  logic        slv_valid;
  logic        to_fire;
  logic        to_rvalid;
  logic        to_wvalid;
  logic        r_rvalid;
  logic        r_wvalid;
  logic [1:0]  r_resp;
  logic [31:0] r_data;

  assign req       = {m1_read | m1_write, m0_read | m0_write};
  assign g_read    = (gnt == MST_M1) ? m1_read  : m0_read;
  assign g_write   = (gnt == MST_M1) ? m1_write : m0_write;
  assign slv_valid = s_readdatavalid | s_writeresponsevalid;

  agh_rr_arb u_rr_arb (
    .req   (req),
    .last  (last),
    .grant (rr_grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      gnt   <= MST_M0;
      last  <= MST_M1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            gnt   <= (rr_grant == 2'b10) ? MST_M1 : MST_M0;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!s_waitrequest) state <= ST_RESP;
        end
        ST_RESP: begin
          if (slv_valid || to_fire) begin
            last  <= gnt;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef AGH_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] to_cnt;
  logic             to_err;
  logic             gnt_rd;

  // Fires on the TIMEOUT_CYCLES-th RESP cycle; a real slave response that cycle still wins.
  assign to_fire   = (state == ST_RESP) && !slv_valid && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign to_rvalid = to_fire && gnt_rd;
  assign to_wvalid = to_fire && !gnt_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
      to_err <= 1'b0;
      gnt_rd <= 1'b0;
    end else begin
      to_cnt <= (state == ST_RESP) ? to_cnt + CNT_W'(1) : '0;
      if (state == ST_ISSUE) gnt_rd <= g_read;
      if (to_fire) to_err <= 1'b1;
    end
  end

  assign err_timeout = to_err;
`else
  logic [31:0] unused_timeout_cycles;

  assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
  assign to_fire     = 1'b0;
  assign to_rvalid   = 1'b0;
  assign to_wvalid   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    s_address    = (gnt == MST_M1) ? m1_address    : m0_address;
    s_byteenable = (gnt == MST_M1) ? m1_byteenable : m0_byteenable;
    s_writedata  = (gnt == MST_M1) ? m1_writedata  : m0_writedata;
    s_read       = (state == ST_ISSUE) && g_read;
    s_write      = (state == ST_ISSUE) && g_write && !g_read;

    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    if (state == ST_ISSUE) begin
      if (gnt == MST_M1) m1_waitrequest = s_waitrequest;
      else               m0_waitrequest = s_waitrequest;
    end

    // Slave responses outside RESP are dropped, so an abandoned transaction cannot leak through.
    r_rvalid = 1'b0;
    r_wvalid = 1'b0;
    r_resp   = RESP_OKAY;
    r_data   = '0;
    if (state == ST_RESP) begin
      if (slv_valid) begin
        r_rvalid = s_readdatavalid;
        r_wvalid = s_writeresponsevalid;
        r_resp   = s_response;
        r_data   = s_readdatavalid ? s_readdata : '0;
      end else if (to_fire) begin
        r_rvalid = to_rvalid;
        r_wvalid = to_wvalid;
        r_resp   = RESP_SLVERR;
      end
    end

    m0_readdatavalid      = (gnt == MST_M0) && r_rvalid;
    m0_writeresponsevalid = (gnt == MST_M0) && r_wvalid;
    m0_response           = (gnt == MST_M0) ? r_resp : 2'b00;
    m0_readdata           = (gnt == MST_M0) ? r_data : '0;
    m1_readdatavalid      = (gnt == MST_M1) && r_rvalid;
    m1_writeresponsevalid = (gnt == MST_M1) && r_wvalid;
    m1_response           = (gnt == MST_M1) ? r_resp : 2'b00;
    m1_readdata           = (gnt == MST_M1) ? r_data : '0;
  end

endmodule

// File: tb/tb_agh_csr_arbiter.sv
// tb/tb_agh_csr_arbiter.sv - scoreboard bench for agh_csr_arbiter
module tb_agh_csr_arbiter;

`ifdef AGH_ARB_TIMEOUT_EN
  localparam int   EXP_TO_N = 8;
  localparam logic EXP_ERR  = 1'b1;
`else
  localparam int   EXP_TO_N = 300;
  localparam logic EXP_ERR  = 1'b0;
`endif

  typedef struct packed {
    logic        m;
    logic        rd;
    logic [1:0]  resp;
    logic [31:0] data;
  } mexp_t;

  typedef struct packed {
    logic        rd;
    logic [9:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } sexp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  m0_address, m1_address, s_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [3:0]  m0_byteenable, m1_byteenable, s_byteenable;
  logic [31:0] m0_writedata, m1_writedata, s_writedata;
  logic        m0_waitrequest, m0_readdatavalid, m0_writeresponsevalid;
  logic        m1_waitrequest, m1_readdatavalid, m1_writeresponsevalid;
  logic [1:0]  m0_response, m1_response, s_response;
  logic [31:0] m0_readdata, m1_readdata, s_readdata;
  logic        s_read, s_write;
  logic        s_waitrequest, s_readdatavalid, s_writeresponsevalid;
  logic        err_timeout;

  mexp_t mq[$];
  sexp_t sq[$];
  int    checks = 0;
  int    errors = 0;
  int    stall_cfg;
  int    resp_lat;

  always #5 clk = ~clk;

  agh_csr_arbiter #(.ADDR_W(10), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdatavalid(m0_readdatavalid),
    .m0_writeresponsevalid(m0_writeresponsevalid), .m0_response(m0_response),
    .m0_readdata(m0_readdata),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdatavalid(m1_readdatavalid),
    .m1_writeresponsevalid(m1_writeresponsevalid), .m1_response(m1_response),
    .m1_readdata(m1_readdata),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_byteenable(s_byteenable), .s_writedata(s_writedata),
    .s_waitrequest(s_waitrequest), .s_readdatavalid(s_readdatavalid),
    .s_writeresponsevalid(s_writeresponsevalid), .s_response(s_response),
    .s_readdata(s_readdata),
    .err_timeout(err_timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_m(input logic m, input logic rd, input logic [1:0] resp, input logic [31:0] data);
    mexp_t e;
    e.m = m; e.rd = rd; e.resp = resp; e.data = data;
    mq.push_back(e);
  endtask

  task automatic push_s(input logic rd, input logic [9:0] addr, input logic [3:0] be, input logic [31:0] wdata);
    sexp_t e;
    e.rd = rd; e.addr = addr; e.be = be; e.wdata = wdata;
    sq.push_back(e);
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds the request until the master sees waitrequest low; returns the stalled cycle count.
  task automatic m_xfer(input int m, input logic rd, input logic wr, input logic [9:0] a,
                        input logic [3:0] be, input logic [31:0] d, output int waits);
    if (m == 0) begin
      m0_address = a; m0_byteenable = be; m0_writedata = d; m0_read = rd; m0_write = wr;
    end else begin
      m1_address = a; m1_byteenable = be; m1_writedata = d; m1_read = rd; m1_write = wr;
    end
    waits = 0;
    forever begin
      @(negedge clk);
      if (((m == 0) ? m0_waitrequest : m1_waitrequest) == 1'b0) break;
      waits++;
      if (waits >= 200) begin
        checks++;
        errors++;
        $display("FAIL xfer_accept m%0d still waiting after %0d cycles, required accept", m, waits);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (m == 0) begin m0_read = 1'b0; m0_write = 1'b0; end
    else        begin m1_read = 1'b0; m1_write = 1'b0; end
  endtask

  // Slave model: read data = address ^ 0xA1, programmable stall and response latency (0 = never).
  initial begin
    int          wcnt;
    int          pend;
    logic        pend_rd;
    logic [31:0] pend_data;
    wcnt = 0; pend = 0; pend_rd = 1'b0; pend_data = '0;
    s_waitrequest = 1'b0; s_readdatavalid = 1'b0; s_writeresponsevalid = 1'b0;
    s_response = 2'b00; s_readdata = '0;
    forever begin
      @(posedge clk);
      #1;
      s_readdatavalid = 1'b0; s_writeresponsevalid = 1'b0; s_response = 2'b00; s_readdata = '0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          if (pend_rd) begin s_readdatavalid = 1'b1; s_readdata = pend_data; end
          else s_writeresponsevalid = 1'b1;
        end
      end
      if (s_read || s_write) begin
        if (wcnt < stall_cfg) begin
          s_waitrequest = 1'b1;
          wcnt++;
        end else begin
          s_waitrequest = 1'b0;
          wcnt = 0;
          if (resp_lat > 0) begin
            pend = resp_lat; pend_rd = s_read; pend_data = {22'h0, s_address} ^ 32'h0000_00A1;
          end
        end
      end else begin
        s_waitrequest = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboards whenever the DUT presents a slave accept or a master response.
  initial begin
    mexp_t me;
    sexp_t se;
    logic  m0v, m1v;
    forever begin
      @(negedge clk);
      if ((s_read || s_write) && !s_waitrequest) begin
        if (sq.size() == 0) chk("s_unexpected_accept", 32'({s_read, s_write}), 32'h0);
        else begin
          se = sq.pop_front();
          chk("s_kind", 32'({s_read, s_write}), se.rd ? 32'h2 : 32'h1);
          chk("s_address", 32'(s_address), 32'(se.addr));
          chk("s_byteenable", 32'(s_byteenable), 32'(se.be));
          if (!se.rd) chk("s_writedata", s_writedata, se.wdata);
        end
      end
      m0v = m0_readdatavalid | m0_writeresponsevalid;
      m1v = m1_readdatavalid | m1_writeresponsevalid;
      if (m0v || m1v) begin
        if (mq.size() == 0) chk("m_unexpected_resp", 32'({m1v, m0v}), 32'h0);
        else begin
          me = mq.pop_front();
          chk("resp_master", 32'({m1v, m0v}), me.m ? 32'h2 : 32'h1);
          if (me.m) begin
            chk("m1_valids", 32'({m1_readdatavalid, m1_writeresponsevalid}), me.rd ? 32'h2 : 32'h1);
            chk("m1_response", 32'(m1_response), 32'(me.resp));
            chk("m1_readdata", m1_readdata, me.data);
            chk("m0_quiet", 32'({m0_response, m0_readdatavalid, m0_writeresponsevalid}) | m0_readdata, 32'h0);
          end else begin
            chk("m0_valids", 32'({m0_readdatavalid, m0_writeresponsevalid}), me.rd ? 32'h2 : 32'h1);
            chk("m0_response", 32'(m0_response), 32'(me.resp));
            chk("m0_readdata", m0_readdata, me.data);
            chk("m1_quiet", 32'({m1_response, m1_readdatavalid, m1_writeresponsevalid}) | m1_readdata, 32'h0);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          w, w0, w1, n;
    logic [31:0] wd [4];
    wd[0] = 32'h1111_1111; wd[1] = 32'h2222_2222; wd[2] = 32'h3333_3333; wd[3] = 32'h4444_4444;
    rst = 1'b1; stall_cfg = 0; resp_lat = 1;
    m0_address = 10'h3FF; m0_read = 1'b1; m0_write = 1'b0; m0_byteenable = 4'hF; m0_writedata = '0;
    m1_address = '0; m1_read = 1'b0; m1_write = 1'b1; m1_byteenable = 4'hF; m1_writedata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_waitrequest", 32'({m1_waitrequest, m0_waitrequest}), 32'h3);
    chk("rst_valids", 32'({m0_readdatavalid, m0_writeresponsevalid, m1_readdatavalid, m1_writeresponsevalid}), 32'h0);
    chk("rst_resp_data", 32'({m0_response, m1_response}) | m0_readdata | m1_readdata, 32'h0);
    chk("rst_s_cmd", 32'({s_read, s_write}), 32'h0);
    chk("rst_err_timeout", 32'(err_timeout), 32'h0);
    @(posedge clk);
    #1;
    m0_read = 1'b0; m1_write = 1'b0; rst = 1'b0;

    for (int r = 0; r < 2; r++) begin
      push_s(1'b0, 10'h020 + 10'(8 * r), 4'hF, wd[2 * r]);     push_m(1'b0, 1'b0, 2'b00, 32'h0);
      push_s(1'b0, 10'h024 + 10'(8 * r), 4'hF, wd[2 * r + 1]); push_m(1'b1, 1'b0, 2'b00, 32'h0);
      fork
        m_xfer(0, 1'b0, 1'b1, 10'h020 + 10'(8 * r), 4'hF, wd[2 * r], w0);
        m_xfer(1, 1'b0, 1'b1, 10'h024 + 10'(8 * r), 4'hF, wd[2 * r + 1], w1);
      join
      chk("rr_m0_waits", 32'(w0), 32'd1);
      chk("rr_m1_waits", 32'(w1), 32'd4);
      gap(3);
    end

    push_s(1'b1, 10'h004, 4'hF, 32'h0); push_m(1'b0, 1'b1, 2'b00, 32'h0000_00A5);
    m_xfer(0, 1'b1, 1'b0, 10'h004, 4'hF, 32'h0, w);
    chk("m0_read_waits", 32'(w), 32'd1);
    @(negedge clk);
    chk("min_latency_rdv", 32'(m0_readdatavalid), 32'h1);
    gap(2);

    push_s(1'b1, 10'h010, 4'hF, 32'h0); push_m(1'b0, 1'b1, 2'b00, 32'h0000_00B1);
    m_xfer(0, 1'b1, 1'b1, 10'h010, 4'hF, 32'hDEAD_BEEF, w);
    gap(3);
    push_s(1'b1, 10'h07E, 4'h3, 32'h0); push_m(1'b1, 1'b1, 2'b00, 32'h0000_00DF);
    m_xfer(1, 1'b1, 1'b0, 10'h07E, 4'h3, 32'h0, w);
    gap(3);

    stall_cfg = 5;
    push_s(1'b0, 10'h030, 4'hC, 32'h55AA_55AA); push_m(1'b1, 1'b0, 2'b00, 32'h0);
    push_s(1'b1, 10'h008, 4'hF, 32'h0);         push_m(1'b0, 1'b1, 2'b00, 32'h0000_00A9);
    fork
      begin
        m_xfer(1, 1'b0, 1'b1, 10'h030, 4'hC, 32'h55AA_55AA, w1);
        stall_cfg = 0;
      end
      begin
        @(posedge clk);
        #1;
        m_xfer(0, 1'b1, 1'b0, 10'h008, 4'hF, 32'h0, w0);
      end
    join
    chk("stall_m1_waits", 32'(w1), 32'd6);
    chk("stall_m0_waits", 32'(w0), 32'd8);
    gap(3);

    resp_lat = 2;
    push_s(1'b1, 10'h00C, 4'hF, 32'h0);
    m_xfer(0, 1'b1, 1'b0, 10'h00C, 4'hF, 32'h0, w);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("late_resp_dropped", 32'({m0_readdatavalid, m0_writeresponsevalid, m1_readdatavalid, m1_writeresponsevalid}), 32'h0);
    chk("late_resp_quiet", 32'({m0_response, m1_response}) | m0_readdata | m1_readdata, 32'h0);
    resp_lat = 1;
    gap(1);
    push_s(1'b1, 10'h014, 4'hF, 32'h0); push_m(1'b0, 1'b1, 2'b00, 32'h0000_00B5);
    m_xfer(0, 1'b1, 1'b0, 10'h014, 4'hF, 32'h0, w);
    chk("post_rst_m0_waits", 32'(w), 32'd1);
    gap(3);

    resp_lat = 0;
    push_s(1'b1, 10'h018, 4'hF, 32'h0);
`ifdef AGH_ARB_TIMEOUT_EN
    push_m(1'b1, 1'b1, 2'b10, 32'h0);
`endif
    m_xfer(1, 1'b1, 1'b0, 10'h018, 4'hF, 32'h0, w);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (m1_readdatavalid || n >= 300) break;
    end
    chk("timeout_resp_cycle", 32'(n), 32'(EXP_TO_N));
    gap(3);
    chk("err_timeout_sticky", 32'(err_timeout), 32'(EXP_ERR));
    rst = 1'b1;
    resp_lat = 1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("err_timeout_cleared", 32'(err_timeout), 32'h0);
    gap(1);
    push_s(1'b0, 10'h3FF, 4'hF, 32'hCAFE_F00D); push_m(1'b1, 1'b0, 2'b00, 32'h0);
    m_xfer(1, 1'b0, 1'b1, 10'h3FF, 4'hF, 32'hCAFE_F00D, w);
    chk("recover_m1_waits", 32'(w), 32'd1);
    gap(4);

    chk("m_queue_drained", 32'(mq.size()), 32'h0);
    chk("s_queue_drained", 32'(sq.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
